// File: rtl/truth_table_sweeper.sv
// Walks a 3-input combinational unit through all eight input vectors, captures
// its response into a truth table and compares the table against a reference.
module truth_table_sweeper #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       out1,
   output logic       busy,
   output logic       done,
   output logic [7:0] truth_table,
   output logic       pass,
   output logic [2:0] mismatch_idx
);

   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t     state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] exp_q, exp_nxt;
   logic [7:0] tt_nxt;
   logic       pass_nxt;
   logic [2:0] mis_nxt;
   logic       busy_nxt, done_nxt;
   logic [2:0] stim_nxt;

   function automatic logic [2:0] first_diff(input logic [7:0] a, input logic [7:0] b);
      first_diff = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (a[i] != b[i]) first_diff = 3'(i);
      end
   endfunction

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= 3'd0;
         cnt          <= 4'd0;
         exp_q        <= 8'd0;
         truth_table  <= 8'd0;
         pass         <= 1'b0;
         mismatch_idx <= 3'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         {in1, in2, in3} <= 3'd0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         cnt          <= cnt_nxt;
         exp_q        <= exp_nxt;
         truth_table  <= tt_nxt;
         pass         <= pass_nxt;
         mismatch_idx <= mis_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         {in1, in2, in3} <= stim_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      exp_nxt   = exp_q;
      tt_nxt    = truth_table;
      pass_nxt  = pass;
      mis_nxt   = mismatch_idx;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = SETTLE;
               idx_nxt   = 3'd0;
               cnt_nxt   = RELOAD;
               exp_nxt   = expected;
               tt_nxt    = 8'd0;
               pass_nxt  = 1'b0;
               mis_nxt   = 3'd0;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_nxt = IDLE;
               pass_nxt  = 1'b0;
               mis_nxt   = 3'd0;
            end else if (cnt == 4'd0) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_nxt = IDLE;
               pass_nxt  = 1'b0;
               mis_nxt   = 3'd0;
            end else begin
               tt_nxt[idx] = out1;
               if (idx == 3'd7) begin
                  // Verdict is taken from the table including the final sample
                  state_nxt = DONE;
                  pass_nxt  = (tt_nxt == exp_q);
                  mis_nxt   = first_diff(tt_nxt, exp_q);
               end else begin
                  state_nxt = SETTLE;
                  idx_nxt   = idx + 3'd1;
                  cnt_nxt   = RELOAD;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      busy_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
      done_nxt = (state_nxt == DONE);
      stim_nxt = busy_nxt ? idx_nxt : 3'd0;
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper driving a unit model whose response
// lags its inputs by exactly SETTLE_CYCLES cycles.
module tb_truth_table_sweeper;

   localparam int S = 3;
   localparam int D = 8 * (S + 1);

   logic       clk = 1'b0;
   logic       rst_n, start, abort;
   logic [7:0] expected;
   logic       in1, in2, in3, out1;
   logic       busy, done, pass;
   logic [7:0] truth_table;
   logic [2:0] mismatch_idx;

   logic [7:0]  lut_q = 8'd0;
   logic [47:0] hist  = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
      .in1(in1), .in2(in2), .in3(in3), .out1(out1), .busy(busy), .done(done),
      .truth_table(truth_table), .pass(pass), .mismatch_idx(mismatch_idx)
   );

   always #5 clk = ~clk;

   // Unit under test: a LUT whose output reflects the inputs from S cycles ago
   always @(posedge clk) hist <= {hist[44:0], in1, in2, in3};
   assign out1 = lut_q[hist[3*(S-1) +: 3]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int low_diff(input logic [7:0] a, input logic [7:0] b);
      for (int i = 0; i < 8; i++) if (a[i] != b[i]) return i;
      return 0;
   endfunction

   task automatic idle_check(input logic [7:0] tt, input logic p, input logic [2:0] m);
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_stim", {in1, in2, in3}, 0);
         check("idle_tt", truth_table, tt);
         check("idle_pass", pass, p);
         check("idle_mis", mismatch_idx, m);
      end
   endtask

   // abort_k < 0: full sweep; otherwise abort is held high during cycle abort_k after accept
   task automatic run_sweep(input logic [7:0] lut, input logic [7:0] expv,
                            input int abort_k, input bit noise);
      int last;
      logic [7:0] cap;
      @(negedge clk);
      lut_q    = lut;
      start    = 1'b1;
      abort    = 1'b0;
      expected = expv;
      last = (abort_k >= 0) ? abort_k + 1 : D;
      cap = 8'd0;
      for (int v = 0; v < 8; v++) if (v * (S + 1) + S < abort_k) cap[v] = lut[v];
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         start    = noise && (abort_k < 0 || k < last) && ($urandom_range(0, 3) == 0);
         abort    = (k == abort_k);
         expected = 8'($urandom);
         if (k < D && (abort_k < 0 || k <= abort_k)) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_stim", {in1, in2, in3}, k / (S + 1));
         end else if (abort_k >= 0) begin
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_stim", {in1, in2, in3}, 0);
            check("abort_tt", truth_table, cap);
            check("abort_pass", pass, 0);
            check("abort_mis", mismatch_idx, 0);
         end else begin
            check("end_done", done, 1);
            check("end_busy", busy, 0);
            check("end_stim", {in1, in2, in3}, 0);
            check("end_tt", truth_table, lut);
            check("end_pass", pass, lut == expv);
            check("end_mis", mismatch_idx, low_diff(lut, expv));
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic reset_mid;
      @(negedge clk);
      lut_q = 8'h96; start = 1'b1; expected = 8'h96;
      @(negedge clk);
      start = 1'b0;
      repeat (5 * (S + 1)) @(negedge clk);
      check("pre_rst_stim", {in1, in2, in3}, 5);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_stim", {in1, in2, in3}, 0);
      check("rst_tt", truth_table, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_mis", mismatch_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] l, e;
      int ak;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 8'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_stim", {in1, in2, in3}, 0);
      check("reset_tt", truth_table, 0);
      check("reset_pass", pass, 0);
      rst_n = 1'b1;

      run_sweep(8'h96, 8'h96, -1, 1'b0);
      run_sweep(8'hE8, 8'hE9, -1, 1'b0);
      idle_check(8'hE8, 1'b0, 3'd0);
      run_sweep(8'h96, 8'h96, 4 * (S + 1) + 1, 1'b0);
      idle_check(8'h06, 1'b0, 3'd0);

      @(negedge clk);
      start = 1'b1; abort = 1'b1; expected = 8'hFF;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      idle_check(8'h06, 1'b0, 3'd0);

      run_sweep(8'h96, 8'h96, -1, 1'b1);
      run_sweep(8'h3C, 8'h3C, -1, 1'b1);
      reset_mid();
      run_sweep(8'h96, 8'h96, -1, 1'b0);
      idle_check(8'h96, 1'b1, 3'd0);

      for (int t = 0; t < 8; t++) begin
         l  = 8'($urandom);
         e  = ($urandom_range(0, 1) == 0) ? l : 8'($urandom);
         ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, D - 1)) : -1;
         run_sweep(l, e, ak, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that drives a 3-input, 1-output combinational unit through all eight input combinations and captures the response into an 8-bit truth table. It compares the captured table against an expected table supplied at start. It replaces hand-written stimulus lists for the combinational exercises and sits between a control source (bench or host FSM) and the unit under test. Input ordering matches the team's exhaustive sweep: in1 is the MSB, in3 the LSB.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; accepted only in IDLE.
- abort  in  1  cancel a sweep in progress.
- expected  in  8  reference truth table; bit i is the expected out1 for vector i; sampled on the start-accept edge.
- in1, in2, in3  out  1 each  stimulus to the unit; {in1,in2,in3} = vector index.
- out1  in  1  response from the unit.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when a sweep completes.
- truth_table  out  8  bit i = out1 captured for vector i.
- pass  out  1  truth_table == expected at completion.
- mismatch_idx  out  3  lowest index where truth_table and expected differ; 0 when pass.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Stimulus driven 0, busy=0.
  - start=1 and abort=0 → latch expected, idx←0, settle counter←SETTLE_CYCLES-1, clear pass and mismatch_idx, go SETTLE.
- SETTLE:
  - Drive idx; busy=1.
  - Counter decrements each cycle; at 0 go SAMPLE.
- SAMPLE:
  - truth_table[idx] ← out1.
  - If idx==7 go DONE; else idx←idx+1, reload counter, go SETTLE.
- DONE:
  - done=1 for one cycle; busy=0; stimulus 0.
  - pass and mismatch_idx are computed from the complete table and registered.
  - Go IDLE.
- Result hold: truth_table, pass and mismatch_idx hold until the next accepted start. On that start, truth_table is cleared to 0.
- Ignored requests:
  - start while busy is ignored.
  - start in DONE is ignored.
- abort:
  - In SETTLE or SAMPLE, abort → IDLE at the next edge.
  - No done pulse; pass=0; mismatch_idx=0; truth_table keeps the bits already captured.
  - If abort and start are both high in IDLE, abort wins and the block stays in IDLE.
- Simultaneous abort in the SAMPLE cycle: abort wins; the sample is not written.
- Reset (asynchronous, any time, including mid-sweep):
  - State IDLE, idx=0, counter=0.
  - in1/in2/in3=0, busy=0, done=0, truth_table=0, pass=0, mismatch_idx=0.
  - After rst_n deasserts, the first start is accepted normally.

## Timing
- All outputs are registered.
- Edge E0 accepts start. From E0 onward:
  - Vector 0 is on in1..in3 and busy=1 in the cycle after E0.
- Per-vector hold: each vector k is held for exactly SETTLE_CYCLES+1 cycles. out1 is sampled at the last rising edge of that window.
- Throughput: the vector index advances every SETTLE_CYCLES+1 cycles, with no gaps between vectors.
- Completion:
  - done is high for the single cycle beginning at edge E0 + 8×(SETTLE_CYCLES+1).
  - busy falls in that same cycle.
  - pass and mismatch_idx are valid in that cycle and after it.
- Back-to-back sweeps: a new start is accepted no earlier than the cycle after done.
- Combinational-path requirement: out1 must settle within SETTLE_CYCLES cycles of a stimulus change.

## Test plan
- XOR3 unit, SETTLE_CYCLES=1, expected=8'h96, start pulse:
  - busy high for 16 cycles, vectors 0..7 each held 2 cycles.
  - done at E0+16; truth_table=8'h96, pass=1, mismatch_idx=0.
- Majority unit, SETTLE_CYCLES=3, expected=8'hE9:
  - done at E0+32; truth_table=8'hE8.
  - pass=0, mismatch_idx=0.
- XOR3 unit, abort asserted while idx=4:
  - IDLE next cycle, stimulus 0, no done.
  - truth_table=8'h06 (bits 0..3 captured), pass=0.
- start re-pulsed at E0+5 and E0+9 during a sweep:
  - Both pulses ignored; single done at E0+16.
  - Then a start at done+1 is accepted.
- rst_n asserted mid-SETTLE at idx=5:
  - All outputs 0 immediately (asynchronously).
  - After release, a fresh sweep completes with the correct table.
- start and abort high together in IDLE → no sweep, busy stays 0.
